world_clock_core: RTL and testbench

Parametrised successor of the single-zone 12/24-hour clock wrapper. It keeps one base time-of-day counter (hh:mm:ss) and N_ZONES per-zone hour offsets. It renders the selected zone as six registered BCD digits in 12- or 24-hour format, edited through the existing pulsed set/up/down buttons. It sits between the button debouncers / 1 Hz tick generator and the 7-segment decoder stage.

---
 rtl/world_clock_core.sv | 161 ++++++++++++++++
 tb/tb_world_clock_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/world_clock_core.sv
// Multi-zone time-of-day core: one base hh:mm:ss counter, per-zone hour offsets,
// button-driven edit FSM and a registered BCD rendering of the selected zone.
module world_clock_core #(
    parameter int N_ZONES      = 4,
    parameter int ZONE_W       = 2,
    parameter int DEFAULT_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              tick,
    input  logic              pulsed_set,
    input  logic              pulsed_up,
    input  logic              pulsed_down,
    output logic [23:0]       digits,
    output logic              is_pm,
    output logic              disp_mode,
    output logic [ZONE_W-1:0] zone,
    output logic [1:0]        state
);
    localparam int NZ_SLOTS = 1 << ZONE_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SET_HOUR   = 2'd1,
        SET_MIN    = 2'd2,
        SET_OFFSET = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [NZ_SLOTS-1:0][4:0] offset;

    // Exactly one button action per cycle: set > up > down.
    logic act_set, act_up, act_down;
    assign act_set  = enable & pulsed_set;
    assign act_up   = enable & pulsed_up & ~pulsed_set;
    assign act_down = enable & pulsed_down & ~pulsed_set & ~pulsed_up;

    logic counting;
    assign counting = (cur_state == IDLE) || (cur_state == SET_OFFSET);

    logic [4:0] hour_inc, hour_dec;
    logic [5:0] min_inc, min_dec;
    assign hour_inc = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    assign hour_dec = (hour == 5'd0) ? 5'd23 : hour - 5'd1;
    assign min_inc  = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
    assign min_dec  = (minute == 6'd0) ? 6'd59 : minute - 6'd1;

    always_ff @(posedge clk) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (act_set) begin
            case (cur_state)
                IDLE:       nxt_state = (zone == '0) ? SET_HOUR : SET_OFFSET;
                SET_HOUR:   nxt_state = SET_MIN;
                SET_MIN:    nxt_state = IDLE;
                SET_OFFSET: nxt_state = IDLE;
                default:    nxt_state = IDLE;
            endcase
        end
    end

    assign state = cur_state;

    // Time is frozen while hour/min are being edited, so tick and edits never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hour   <= 5'd0;
            minute <= 6'd0;
            second <= 6'd0;
        end else begin
            if (counting && tick) begin
                if (second == 6'd59) begin
                    second <= 6'd0;
                    minute <= min_inc;
                    if (minute == 6'd59) hour <= hour_inc;
                end else begin
                    second <= second + 6'd1;
                end
            end
            case (cur_state)
                SET_HOUR: begin
                    if (act_up)        hour <= hour_inc;
                    else if (act_down) hour <= hour_dec;
                end
                SET_MIN: begin
                    if (act_set)       second <= 6'd0;
                    else if (act_up)   minute <= min_inc;
                    else if (act_down) minute <= min_dec;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zone      <= '0;
            disp_mode <= (DEFAULT_MODE != 0);
        end else if (cur_state == IDLE) begin
            if (act_up)
                disp_mode <= ~disp_mode;
            else if (act_down)
                zone <= (zone == ZONE_W'(N_ZONES - 1)) ? '0 : zone + 1'b1;
        end
    end

    // Zone 0 and unused index slots are hard-wired to a zero offset.
    for (genvar z = 0; z < NZ_SLOTS; z++) begin : g_off
        if (z > 0 && z < N_ZONES) begin : g_live
            logic [4:0] off_q;
            always_ff @(posedge clk) begin
                if (reset)
                    off_q <= 5'd0;
                else if (cur_state == SET_OFFSET && zone == ZONE_W'(z)) begin
                    if (act_up)        off_q <= (off_q == 5'd23) ? 5'd0 : off_q + 5'd1;
                    else if (act_down) off_q <= (off_q == 5'd0) ? 5'd23 : off_q - 5'd1;
                end
            end
            assign offset[z] = off_q;
        end else begin : g_fixed
            assign offset[z] = 5'd0;
        end
    end

    function automatic logic [7:0] bcd(input logic [5:0] v);
        logic [3:0] t;
        if (v >= 6'd60)      t = 4'd6;
        else if (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return {t, 4'(v - 6'(t) * 6'd10)};
    endfunction

    logic [5:0] hsum, dhour, h12, hshow;
    assign hsum  = {1'b0, hour} + {1'b0, offset[zone]};
    assign dhour = (hsum >= 6'd24) ? hsum - 6'd24 : hsum;
    assign h12   = (dhour == 6'd0) ? 6'd12 : (dhour > 6'd12) ? dhour - 6'd12 : dhour;
    assign hshow = disp_mode ? h12 : dhour;

    always_ff @(posedge clk) begin
        if (reset) begin
            digits <= 24'h000000;
            is_pm  <= 1'b0;
        end else begin
            digits <= {bcd(hshow), bcd(minute), bcd(second)};
            is_pm  <= (dhour >= 6'd12);
        end
    end
endmodule

// File: tb/tb_world_clock_core.sv
// Scoreboarded bench: a seconds-of-day reference model predicts every cycle's outputs,
// a negedge monitor compares them; directed checks cover the documented scenarios.
module tb_world_clock_core;
    localparam int NZ = 4;
    localparam int ZW = 2;
    localparam int DM = 0;

    logic clk = 1'b0;
    logic reset, enable, tick, pulsed_set, pulsed_up, pulsed_down;
    logic [23:0]   digits;
    logic          is_pm, disp_mode;
    logic [ZW-1:0] zone;
    logic [1:0]    state;

    world_clock_core #(.N_ZONES(NZ), .ZONE_W(ZW), .DEFAULT_MODE(DM)) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
        .digits(digits), .is_pm(is_pm), .disp_mode(disp_mode), .zone(zone), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0]   dig;
        logic          pm;
        logic [1:0]    st;
        logic [ZW-1:0] zn;
        logic          md;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time as seconds of day, plain integers for everything else.
    int m_t, m_zn, m_md, m_st;
    int m_off[NZ];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [24:0] render();
        int dh, h, mi, se;
        dh = (m_t / 3600 + m_off[m_zn]) % 24;
        mi = (m_t / 60) % 60;
        se = m_t % 60;
        h  = m_md ? ((dh % 12 == 0) ? 12 : dh % 12) : dh;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10),
                (dh >= 12) ? 1'b1 : 1'b0};
    endfunction

    task automatic model_step(input bit en, tk, s, u, d, r);
        exp_t e;
        bit a_s, a_u, a_d;
        int h, mi, se;
        logic [24:0] rv;
        a_s = en && s;
        a_u = en && u && !s;
        a_d = en && d && !s && !u;
        if (r) begin
            e.dig = 24'h0; e.pm = 1'b0;
            m_t = 0; m_zn = 0; m_md = DM; m_st = 0;
            for (int i = 0; i < NZ; i++) m_off[i] = 0;
        end else begin
            rv = render();
            e.dig = rv[24:1]; e.pm = rv[0];
            if (tk && (m_st == 0 || m_st == 3)) m_t = (m_t + 1) % 86400;
            h = m_t / 3600; mi = (m_t / 60) % 60; se = m_t % 60;
            case (m_st)
                0: if (a_s) m_st = (m_zn == 0) ? 1 : 3;
                   else if (a_u) m_md = 1 - m_md;
                   else if (a_d) m_zn = (m_zn + 1) % NZ;
                1: if (a_s) m_st = 2;
                   else if (a_u) h = (h + 1) % 24;
                   else if (a_d) h = (h + 23) % 24;
                2: if (a_s) begin m_st = 0; se = 0; end
                   else if (a_u) mi = (mi + 1) % 60;
                   else if (a_d) mi = (mi + 59) % 60;
                default: if (a_s) m_st = 0;
                   else if (a_u) m_off[m_zn] = (m_off[m_zn] + 1) % 24;
                   else if (a_d) m_off[m_zn] = (m_off[m_zn] + 23) % 24;
            endcase
            m_t = h * 3600 + mi * 60 + se;
        end
        e.st = 2'(m_st);
        e.zn = ZW'(m_zn);
        e.md = 1'(m_md);
        q.push_back(e);
    endtask

    // Drive at negedge, let the DUT take the edge, record the prediction, rest at negedge.
    task automatic cycle(input bit en, tk, s, u, d, r);
        enable = en; tick = tk; pulsed_set = s; pulsed_up = u; pulsed_down = d; reset = r;
        @(posedge clk);
        model_step(en, tk, s, u, d, r);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1, 0, 0, 0, 0, 0);
    endtask
    task automatic ticks(input int n);
        repeat (n) cycle(1, 1, 0, 0, 0, 0);
    endtask
    task automatic p_set(input int n);
        repeat (n) cycle(1, 0, 1, 0, 0, 0);
    endtask
    task automatic p_up(input int n);
        repeat (n) cycle(1, 0, 0, 1, 0, 0);
    endtask
    task automatic p_down(input int n);
        repeat (n) cycle(1, 0, 0, 0, 1, 0);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            chk("sb_digits", 32'(digits), 32'(me.dig));
            chk("sb_is_pm", 32'(is_pm), 32'(me.pm));
            chk("sb_state", 32'(state), 32'(me.st));
            chk("sb_zone", 32'(zone), 32'(me.zn));
            chk("sb_mode", 32'(disp_mode), 32'(me.md));
        end
    end

    initial begin
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        chk("reset_digits", 32'(digits), 32'h000000);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_zone", 32'(zone), 32'd0);
        chk("reset_mode", 32'(disp_mode), 32'(DM));

        ticks(61);
        idle(2);
        chk("61_ticks", 32'(digits), 32'h000101);
        chk("61_ticks_pm", 32'(is_pm), 32'd0);

        // Edit to 23:59 with a tick inside SET_MIN that must be ignored.
        p_set(1); p_down(1); p_set(1);
        cycle(1, 1, 0, 0, 0, 0);
        p_down(2); p_set(1);
        chk("edit_done_state", 32'(state), 32'd0);
        ticks(60);
        idle(1);
        chk("midnight_wrap", 32'(digits), 32'h000000);
        chk("midnight_pm", 32'(is_pm), 32'd0);

        // 12-hour rendering at 13, 0 and 12.
        p_up(1);
        chk("mode_12h", 32'(disp_mode), 32'd1);
        p_set(1); p_up(13); p_set(1); p_up(5); p_set(1);
        idle(1);
        chk("h13_12h", 32'(digits), 32'h010500);
        chk("h13_pm", 32'(is_pm), 32'd1);
        p_set(1); p_down(13); p_set(2);
        idle(1);
        chk("h0_12h", 32'(digits), 32'h120500);
        chk("h0_pm", 32'(is_pm), 32'd0);
        p_set(1); p_up(12); p_set(2);
        idle(1);
        chk("h12_12h", 32'(digits), 32'h120500);
        chk("h12_pm", 32'(is_pm), 32'd1);

        // Zones: base 20:00, zone 1 offset +9 wraps to 05.
        p_up(1);
        p_set(1); p_up(8); p_set(1); p_down(5); p_set(1);
        idle(1);
        chk("base_2000", 32'(digits), 32'h200000);
        p_down(1); p_set(1);
        chk("set_offset_state", 32'(state), 32'd3);
        p_up(9); p_set(1);
        idle(1);
        chk("zone1_digits", 32'(digits), 32'h050000);
        p_down(3);
        idle(1);
        chk("zone_wrap", 32'(zone), 32'd0);
        chk("zone0_digits", 32'(digits), 32'h200000);

        // Priority and enable gating.
        cycle(1, 0, 1, 1, 0, 0);
        chk("set_over_up_state", 32'(state), 32'd1);
        chk("set_over_up_mode", 32'(disp_mode), 32'd0);
        p_set(2);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 1, 0);
        chk("disabled_state", 32'(state), 32'd0);
        chk("disabled_zone", 32'(zone), 32'd0);
        chk("disabled_mode", 32'(disp_mode), 32'd0);
        idle(1);
        chk("disabled_ticks", 32'(digits), 32'h200003);

        // Reset in the middle of an offset edit.
        p_down(2); p_set(1); p_up(7);
        cycle(1, 0, 0, 0, 0, 1);
        chk("midedit_rst_state", 32'(state), 32'd0);
        chk("midedit_rst_zone", 32'(zone), 32'd0);
        idle(1);
        chk("midedit_rst_digits", 32'(digits), 32'h000000);
        p_down(2); idle(2);
        chk("offset2_cleared", 32'(digits), 32'h000000);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
